// File: rtl/gpio_pin_ctrl_pkg.sv
// Shared defaults and helpers for the GPIO pin controller.
package gpio_pin_ctrl_pkg;

  localparam int unsigned NUM_PINS_DEF    = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DB_W_DEF        = 4;

  // True when a debounced edge on a pin is one the software asked to see.
  function automatic logic edge_hit(input logic rise, input logic fall,
                                    input logic rise_en, input logic fall_en);
    return (rise & rise_en) | (fall & fall_en);
  endfunction

endpackage

// File: rtl/gpio_pin_sync_db.sv
// Per-pin input path: synchroniser, debounce counter, stable value and
// single-cycle rise/fall pulses that coincide with the edge updating in_o.
module gpio_pin_sync_db
  import gpio_pin_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_W        = DB_W_DEF
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            pad_i,
  input  logic [DB_W-1:0] db_limit_i,
  output logic            in_o,
  output logic            rise_o,
  output logic            fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        cnt_q;
  logic                   in_q;
  logic                   s;
  logic                   upd;

  assign s = sync_q[SYNC_STAGES-1];

  // The compare uses the live limit, so lowering it mid-count takes effect at once.
  assign upd = (s != in_q) && (cnt_q >= db_limit_i);

  // Pulses are combinational so status registers them on the same edge as in_q.
  assign rise_o = upd & s;
  assign fall_o = upd & ~s;
  assign in_o   = in_q;

  // Shift the asynchronous pad value through the synchroniser chain.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  // Accept a new level only after it has disagreed for db_limit_i + 1 samples.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
      in_q  <= 1'b0;
    end else if (s == in_q) begin
      cnt_q <= '0;
    end else if (cnt_q >= db_limit_i) begin
      in_q  <= s;
      cnt_q <= '0;
    end else begin
      // cnt_q < db_limit_i here, so the increment cannot wrap.
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_pin_ctrl.sv
// Core-side controller for a bank of io_pad instances: registered pad drive,
// per-pin debounced input with edge detection, sticky edge status and irq.
module gpio_pin_ctrl
  import gpio_pin_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PINS    = NUM_PINS_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_W        = DB_W_DEF
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic [NUM_PINS-1:0] dir_i,
  input  logic [NUM_PINS-1:0] out_i,
  input  logic [NUM_PINS-1:0] pull_i,
  input  logic [DB_W-1:0]     db_limit_i,
  input  logic [NUM_PINS-1:0] rise_en_i,
  input  logic [NUM_PINS-1:0] fall_en_i,
  input  logic [NUM_PINS-1:0] irq_clr_i,
  output logic [NUM_PINS-1:0] pad_wen_o,
  output logic [NUM_PINS-1:0] pad_wdata_o,
  output logic [NUM_PINS-1:0] pad_pull_o,
  input  logic [NUM_PINS-1:0] pad_rdata_i,
  output logic [NUM_PINS-1:0] in_o,
  output logic [NUM_PINS-1:0] irq_status_o,
  output logic                irq_o
);

  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] fall;
  logic [NUM_PINS-1:0] status_set;
  logic [NUM_PINS-1:0] status_q;

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    gpio_pin_sync_db #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_W       (DB_W)
    ) u_sync_db (
      .clk_i     (clk_i),
      .arst_i    (arst_i),
      .pad_i     (pad_rdata_i[g]),
      .db_limit_i(db_limit_i),
      .in_o      (in_o[g]),
      .rise_o    (rise[g]),
      .fall_o    (fall[g])
    );

    assign status_set[g] = edge_hit(rise[g], fall[g], rise_en_i[g], fall_en_i[g]);
  end

  // Register the pad controls; pull is suppressed while the pad is driven.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pad_wen_o   <= '0;
      pad_wdata_o <= '0;
      pad_pull_o  <= '0;
    end else begin
      pad_wen_o   <= dir_i;
      pad_wdata_o <= out_i;
      pad_pull_o  <= pull_i & ~dir_i;
    end
  end

  // Sticky status: write-1-to-clear, a coincident new edge wins over the clear.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~irq_clr_i) | status_set;
    end
  end

  assign irq_status_o = status_q;
  assign irq_o        = |status_q;

endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// Scoreboard bench for gpio_pin_ctrl: stimulus pushes expected values tagged
// with the cycle they must appear in; a monitor pops and compares at negedge.
module tb_gpio_pin_ctrl;

  localparam int K_IN  = 0;
  localparam int K_ST  = 1;
  localparam int K_IRQ = 2;
  localparam int K_WEN = 3;
  localparam int K_WD  = 4;
  localparam int K_PU  = 5;

  typedef struct {
    int         at;
    int         kind;
    logic [7:0] mask;
    logic [7:0] val;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       arst_i;
  logic [7:0] dir_i, out_i, pull_i, rise_en_i, fall_en_i, irq_clr_i;
  logic [3:0] db_limit_i;
  logic [7:0] pad_wen_o, pad_wdata_o, pad_pull_o, pad_rdata_i;
  logic [7:0] in_o, irq_status_o;
  logic       irq_o;
  logic [7:0] ext_val;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // Model state for the random loopback phase.
  bit         model_on = 1'b0;
  logic [7:0] m_s0, m_s1, m_in, m_st;
  int         m_cnt[8];

  gpio_pin_ctrl dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .dir_i       (dir_i),
    .out_i       (out_i),
    .pull_i      (pull_i),
    .db_limit_i  (db_limit_i),
    .rise_en_i   (rise_en_i),
    .fall_en_i   (fall_en_i),
    .irq_clr_i   (irq_clr_i),
    .pad_wen_o   (pad_wen_o),
    .pad_wdata_o (pad_wdata_o),
    .pad_pull_o  (pad_pull_o),
    .pad_rdata_i (pad_rdata_i),
    .in_o        (in_o),
    .irq_status_o(irq_status_o),
    .irq_o       (irq_o)
  );

  // Pad model: driven or pulled pads show wdata, floating pads show ext_val.
  assign pad_rdata_i = ((pad_wen_o | pad_pull_o) & pad_wdata_o) |
                       (~(pad_wen_o | pad_pull_o) & ext_val);

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic exp_push(input int at, input int kind, input logic [7:0] mask,
                          input logic [7:0] val);
    exp_t e;
    e.at = at; e.kind = kind; e.mask = mask; e.val = val;
    q.push_back(e);
  endtask

  task automatic exp_all_zero(input int at);
    for (int k = K_IN; k <= K_PU; k++) exp_push(at, k, 8'hFF, 8'h00);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] actual(input int kind);
    case (kind)
      K_IN:    return in_o;
      K_ST:    return irq_status_o;
      K_IRQ:   return {7'b0, irq_o};
      K_WEN:   return pad_wen_o;
      K_WD:    return pad_wdata_o;
      default: return pad_pull_o;
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_IN:    return "in_o";
      K_ST:    return "irq_status_o";
      K_IRQ:   return "irq_o";
      K_WEN:   return "pad_wen_o";
      K_WD:    return "pad_wdata_o";
      default: return "pad_pull_o";
    endcase
  endfunction

  task automatic monitor_step();
    int i = 0;
    while (i < q.size()) begin
      if (q[i].at == cyc) begin
        logic [7:0] a;
        a = actual(q[i].kind) & q[i].mask;
        checks++;
        if (a !== (q[i].val & q[i].mask)) begin
          errors++;
          $display("FAIL %s cycle %0d: got %b want %b (mask %b)",
                   kname(q[i].kind), cyc, a, q[i].val & q[i].mask, q[i].mask);
        end
        q.delete(i);
      end else if (q[i].at < cyc) begin
        errors++;
        $display("FAIL stale_%s cycle %0d: expectation for cycle %0d never compared",
                 kname(q[i].kind), cyc, q[i].at);
        q.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  // Reference model: predicts the outputs after the next edge from the
  // inputs stable at this negedge.
  task automatic model_step();
    logic [7:0] s, rise, fall;
    if (!model_on) return;
    if (arst_i) begin
      m_s0 = '0; m_s1 = '0; m_in = '0; m_st = '0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      return;
    end
    s = m_s1; rise = '0; fall = '0;
    for (int i = 0; i < 8; i++) begin
      if (s[i] == m_in[i]) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] >= int'(db_limit_i)) begin
        m_in[i]  = s[i];
        m_cnt[i] = 0;
        if (s[i]) rise[i] = 1'b1; else fall[i] = 1'b1;
      end else begin
        m_cnt[i]++;
      end
    end
    m_s1 = m_s0;
    m_s0 = pad_rdata_i;
    m_st = (m_st & ~irq_clr_i) | (rise & rise_en_i) | (fall & fall_en_i);
    exp_push(cyc + 1, K_IN,  8'hFF, m_in);
    exp_push(cyc + 1, K_ST,  8'hFF, m_st);
    exp_push(cyc + 1, K_IRQ, 8'h01, {7'b0, |m_st});
  endtask

  initial forever begin
    @(negedge clk_i);
    model_step();
    monitor_step();
  end

  initial begin
    int c;
    arst_i = 1'b1;
    dir_i = '0; out_i = '0; pull_i = '0; rise_en_i = '0; fall_en_i = '0;
    irq_clr_i = '0; db_limit_i = 4'd3; ext_val = '0;

    // Reset values.
    step(2);
    exp_all_zero(cyc);
    step(1);
    arst_i = 1'b0;
    step(3);

    // Drive path on pin 3.
    c = cyc; dir_i = 8'h08; out_i = 8'h08;
    exp_push(c + 1, K_WEN, 8'h08, 8'h08);
    exp_push(c + 1, K_WD,  8'h08, 8'h08);
    step(1);
    c = cyc; dir_i = 8'h00; pull_i = 8'h08;
    exp_push(c + 1, K_PU,  8'h08, 8'h08);
    exp_push(c + 1, K_WEN, 8'h08, 8'h00);
    step(1);
    c = cyc; dir_i = 8'h08; pull_i = 8'h08;
    exp_push(c + 1, K_PU,  8'h08, 8'h00);
    exp_push(c + 1, K_WEN, 8'h08, 8'h08);
    step(1);
    dir_i = '0; out_i = '0; pull_i = '0;
    step(10);

    // Debounce db_limit=3: 3-cycle glitch is filtered.
    c = cyc; ext_val[0] = 1'b1;
    for (int k = 1; k <= 9; k++) exp_push(c + k, K_IN, 8'h01, 8'h00);
    step(3);
    ext_val[0] = 1'b0;
    step(8);

    // 4-cycle pulse: rise 5 edges after first sampled edge, fall likewise.
    c = cyc; ext_val[0] = 1'b1;
    exp_push(c + 5,  K_IN, 8'h01, 8'h00);
    exp_push(c + 6,  K_IN, 8'h01, 8'h01);
    exp_push(c + 9,  K_IN, 8'h01, 8'h01);
    exp_push(c + 10, K_IN, 8'h01, 8'h00);
    step(4);
    ext_val[0] = 1'b0;
    step(10);

    // db_limit=0: two edges after the first sampled edge.
    c = cyc; db_limit_i = 4'd0; ext_val[0] = 1'b1;
    exp_push(c + 2, K_IN, 8'h01, 8'h00);
    exp_push(c + 3, K_IN, 8'h01, 8'h01);
    step(4);
    ext_val[0] = 1'b0;
    step(6);

    // Limit lowered mid-count: counter already past new limit, update next edge.
    c = cyc; db_limit_i = 4'd3; ext_val[0] = 1'b1;
    step(4);
    db_limit_i = 4'd0;
    exp_push(c + 4, K_IN, 8'h01, 8'h00);
    exp_push(c + 5, K_IN, 8'h01, 8'h01);
    step(2);
    ext_val[0] = 1'b0;
    step(6);

    // Rising-edge interrupt on pin 1, fall not enabled, then clear.
    c = cyc; rise_en_i = 8'h02; fall_en_i = 8'h00; ext_val[1] = 1'b1;
    exp_push(c + 2, K_ST,  8'h02, 8'h00);
    exp_push(c + 3, K_ST,  8'h02, 8'h02);
    exp_push(c + 3, K_IRQ, 8'h01, 8'h01);
    step(4);
    ext_val[1] = 1'b0;
    exp_push(c + 7, K_IN,  8'h02, 8'h00);
    exp_push(c + 7, K_ST,  8'hFF, 8'h02);
    step(5);
    irq_clr_i = 8'h02;
    exp_push(c + 9,  K_ST,  8'h02, 8'h02);
    exp_push(c + 10, K_ST,  8'hFF, 8'h00);
    exp_push(c + 10, K_IRQ, 8'h01, 8'h00);
    step(1);
    irq_clr_i = '0;
    step(3);

    // Set/clear collision on pin 2: set wins.
    c = cyc; rise_en_i = 8'h04; ext_val[2] = 1'b1;
    step(2);
    irq_clr_i = 8'h04;
    exp_push(c + 3, K_ST, 8'h04, 8'h04);
    exp_push(c + 4, K_ST, 8'h04, 8'h04);
    step(1);
    irq_clr_i = '0;
    step(2);

    // Reset mid-count with status set: everything drops immediately.
    c = cyc; rise_en_i = '0; db_limit_i = 4'd3; ext_val[0] = 1'b1;
    step(4);
    arst_i = 1'b1;
    exp_all_zero(cyc);
    step(2);
    arst_i = 1'b0;
    c = cyc;
    exp_push(c + 5, K_IN, 8'h01, 8'h00);
    exp_push(c + 6, K_IN, 8'h01, 8'h01);
    exp_push(c + 6, K_ST, 8'hFF, 8'h00);
    step(8);
    ext_val = '0;
    step(8);

    // Random loopback against the reference model.
    model_on = 1'b1;
    arst_i = 1'b1;
    db_limit_i = 4'd1; rise_en_i = 8'hA5; fall_en_i = 8'h3C;
    step(2);
    arst_i = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (n % 16 == 0) begin
        dir_i  = 8'($urandom);
        pull_i = 8'($urandom);
      end
      out_i     = out_i ^ (8'($urandom) & 8'($urandom));
      ext_val   = 8'($urandom);
      irq_clr_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(1);
    end
    model_on = 1'b0;
    dir_i = '0; out_i = '0; pull_i = '0; irq_clr_i = '0;

    for (int w = 0; w < 20 && q.size() != 0; w++) @(negedge clk_i);
    #1;
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
